// File: rtl/alu_cmd_pkg.sv
// Shared constants for the ALU command sequencer: ALU opcodes, opcode-byte fields, flag bits, FSM states.
// Pure definitions; no timing or flow-control behaviour of its own.
package alu_cmd_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SHL = 3'b100;
    localparam logic [2:0] ALU_SHR = 3'b101;

    localparam int OPB_OP_LO    = 0;
    localparam int OPB_SHAMT_LO = 3;
    localparam int OPB_USE_ACC  = 5;
    localparam int OPB_RSVD_LO  = 6;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_NEG   = 1;
    localparam int FLG_CARRY = 2;
    localparam int FLG_OVF   = 3;
    localparam int FLG_ERR   = 4;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == ALU_SHL) || (op == ALU_SHR);
    endfunction

    function automatic logic opcode_legal(input logic [7:0] opb);
        return (opb[OPB_RSVD_LO +: 2] == 2'b00) &&
               (opb[OPB_OP_LO +: 3] <= ALU_SHR);
    endfunction

endpackage

// File: rtl/ALU_simple.sv
// Combinational 8-bit ALU: add/sub/and/or/shl/shr with zero/negative/carry/overflow flags.
// Zero latency, no flow control.
module ALU_simple
    import alu_cmd_pkg::*;
(
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] Op,
    input  logic [1:0] Shamt,
    output logic [7:0] Result,
    output logic       Zero,
    output logic       Negative,
    output logic       Carry,
    output logic       Overflow
);

    logic [8:0] sum9;
    logic [2:0] shl_idx;
    logic [2:0] shr_idx;

    // shr with Shamt 0 wraps to index 7; the sequencer masks that carry.
    assign shl_idx = 3'd7 - {1'b0, Shamt};
    assign shr_idx = {1'b0, Shamt} - 3'd1;

    always_comb begin
        sum9     = 9'd0;
        Result   = 8'h00;
        Carry    = 1'b0;
        Overflow = 1'b0;
        case (Op)
            ALU_ADD: begin
                sum9     = {1'b0, A} + {1'b0, B};
                Result   = sum9[7:0];
                Carry    = sum9[8];
                Overflow = (A[7] == B[7]) && (sum9[7] != A[7]);
            end
            ALU_SUB: begin
                sum9     = {1'b0, A} - {1'b0, B};
                Result   = sum9[7:0];
                Carry    = sum9[8];
                Overflow = (A[7] != B[7]) && (sum9[7] != A[7]);
            end
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SHL: begin
                Result = A << Shamt;
                Carry  = A[shl_idx];
            end
            ALU_SHR: begin
                Result = A >> Shamt;
                Carry  = A[shr_idx];
            end
            default: Result = 8'h00;
        endcase
    end

    assign Zero     = (Result == 8'h00);
    assign Negative = Result[7];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-serial ALU front end: opcode + 0..2 operands in, registered result/flags out, 8-bit accumulator.
// Result valid one cycle after last operand (same edge for illegal opcodes); holds output until out_ready, no input taken meanwhile.
module alu_cmd_sequencer
    import alu_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic [4:0] out_flags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    state_t     state_q;
    logic [2:0] op_q;
    logic [1:0] sh_q;
    logic       use_acc_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] acc_q;
    logic [7:0] res_q;
    logic [4:0] flags_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       busy_q;

    logic       accept;
    logic [7:0] alu_a;
    logic [7:0] alu_res;
    logic       alu_zero;
    logic       alu_neg;
    logic       alu_carry;
    logic       alu_ovf;
    logic [4:0] flags_d;
    logic [2:0] in_op;

    assign accept = in_valid && in_ready_q;
    assign in_op  = in_data[OPB_OP_LO +: 3];
    assign alu_a  = use_acc_q ? acc_q : a_q;

    ALU_simple u_alu (
        .A        (alu_a),
        .B        (b_q),
        .Op       (op_q),
        .Shamt    (sh_q),
        .Result   (alu_res),
        .Zero     (alu_zero),
        .Negative (alu_neg),
        .Carry    (alu_carry),
        .Overflow (alu_ovf)
    );

    always_comb begin
        flags_d            = 5'b00000;
        flags_d[FLG_ZERO]  = alu_zero;
        flags_d[FLG_NEG]   = alu_neg;
        flags_d[FLG_CARRY] = alu_carry && !((op_q == ALU_SHR) && (sh_q == 2'd0));
        flags_d[FLG_OVF]   = alu_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_OP;
            op_q        <= 3'd0;
            sh_q        <= 2'd0;
            use_acc_q   <= 1'b0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            acc_q       <= 8'h00;
            res_q       <= 8'h00;
            flags_q     <= 5'b00000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_OP: begin
                    if (accept) begin
                        op_q      <= in_op;
                        sh_q      <= in_data[OPB_SHAMT_LO +: 2];
                        use_acc_q <= in_data[OPB_USE_ACC];
                        b_q       <= 8'h00;
                        busy_q    <= 1'b1;
                        if (!opcode_legal(in_data)) begin
                            res_q       <= 8'h00;
                            flags_q     <= 5'b10000;
                            state_q     <= S_OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else if (in_data[OPB_USE_ACC]) begin
                            if (is_shift(in_op)) begin
                                state_q    <= S_EXEC;
                                in_ready_q <= 1'b0;
                            end else begin
                                state_q <= S_B;
                            end
                        end else begin
                            state_q <= S_A;
                        end
                    end
                end
                S_A: begin
                    if (accept) begin
                        a_q <= in_data;
                        if (is_shift(op_q)) begin
                            state_q    <= S_EXEC;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (accept) begin
                        b_q        <= in_data;
                        state_q    <= S_EXEC;
                        in_ready_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    res_q       <= alu_res;
                    flags_q     <= flags_d;
                    acc_q       <= alu_res;
                    state_q     <= S_OUT;
                    out_valid_q <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        state_q     <= S_OP;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_OP;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = res_q;
    assign out_flags = flags_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with an arithmetic reference model and a per-cycle output checker.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic [4:0] out_flags;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic       checking = 1'b0;
    logic       exp_vld  = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic [4:0] exp_flags = 5'b00000;
    logic [7:0] m_acc = 8'h00;

    alu_cmd_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: returns {flags, data} from plain signed/unsigned arithmetic.
    function automatic logic [12:0] model(input logic [7:0] opb, input logic [7:0] a, input logic [7:0] b);
        int av, bv, sa, sb, r, sr, sh;
        logic c, v, z, n;
        logic [7:0] r8;
        if (opb[7:6] != 2'b00 || opb[2:0] > 3'd5)
            return {5'b10000, 8'h00};
        av = int'(a); bv = int'(b);
        sa = (av > 127) ? av - 256 : av;
        sb = (bv > 127) ? bv - 256 : bv;
        sh = int'(opb[4:3]);
        c = 1'b0; v = 1'b0; r = 0;
        case (opb[2:0])
            3'd0: begin r = av + bv; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            3'd1: begin r = av - bv; c = (av < bv); sr = sa - sb; v = (sr > 127) || (sr < -128); end
            3'd2: r = av & bv;
            3'd3: r = av | bv;
            3'd4: begin r = av << sh; c = ((av >> (7 - sh)) & 1) != 0; end
            default: begin r = av >> sh; c = (sh == 0) ? 1'b0 : (((av >> (sh - 1)) & 1) != 0); end
        endcase
        r8 = 8'(r & 255);
        z = (r8 == 8'h00);
        n = r8[7];
        return {1'b0, v, c, n, z, r8};
    endfunction

    always @(negedge clk) begin
        if (checking && !rst) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
            if (exp_vld) begin
                chk("out_data", {24'd0, out_data}, {24'd0, exp_data});
                chk("out_flags", {27'd0, out_flags}, {27'd0, exp_flags});
                chk("in_ready_while_out", {31'd0, in_ready}, 32'd0);
                chk("busy_while_out", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] opb, input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [12:0] m;
        logic legal, use_acc, shift;
        int t;
        legal   = (opb[7:6] == 2'b00) && (opb[2:0] <= 3'd5);
        use_acc = opb[5];
        shift   = (opb[2:0] == 3'd4) || (opb[2:0] == 3'd5);
        m = model(opb, use_acc ? m_acc : a, shift ? 8'h00 : b);
        exp_data  = m[7:0];
        exp_flags = m[12:8];
        send_byte(opb);
        if (legal) begin
            if (!use_acc) send_byte(a);
            if (!shift) send_byte(b);
            chk("exec_no_valid", {31'd0, out_valid}, 32'd0);
            chk("exec_no_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            m_acc = m[7:0];
        end
        exp_vld = 1'b1;
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        for (t = 0; t < hold; t++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_vld   = 1'b0;
        chk("ready_after_hs", {31'd0, in_ready}, 32'd1);
        chk("busy_after_hs", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_flags", {27'd0, out_flags}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_vals();

        chk("model_add", {19'd0, model(8'h00, 8'h7F, 8'h01)}, {19'd0, 5'b01010, 8'h80});
        chk("model_sub", {19'd0, model(8'h01, 8'h05, 8'h07)}, {19'd0, 5'b00110, 8'hFE});
        chk("model_shl", {19'd0, model(8'h2C, 8'hFE, 8'h00)}, {19'd0, 5'b00110, 8'hFC});
        chk("model_shr0", {19'd0, model(8'h05, 8'h81, 8'h00)}, {19'd0, 5'b00010, 8'h81});
        chk("model_ill", {19'd0, model(8'hC0, 8'h12, 8'h34)}, {19'd0, 5'b10000, 8'h00});
        chk("model_and", {19'd0, model(8'h02, 8'hF0, 8'h3C)}, {19'd0, 5'b00000, 8'h30});
        checking = 1'b1;

        run_cmd(8'h00, 8'h7F, 8'h01, 0);
        chk("add_hold_data", {24'd0, out_data}, 32'h80);
        chk("add_hold_flags", {27'd0, out_flags}, 32'b01010);
        run_cmd(8'h01, 8'h05, 8'h07, 5);
        chk("sub_data", {24'd0, out_data}, 32'hFE);
        run_cmd(8'h2C, 8'h00, 8'h00, 0);
        chk("acc_shl_data", {24'd0, out_data}, 32'hFC);
        chk("acc_shl_flags", {27'd0, out_flags}, 32'b00110);
        run_cmd(8'h05, 8'h81, 8'h00, 0);
        chk("shr0_flags", {27'd0, out_flags}, 32'b00010);
        run_cmd(8'h06, 8'h00, 8'h00, 0);
        chk("ill06_flags", {27'd0, out_flags}, 32'b10000);
        run_cmd(8'hC0, 8'h00, 8'h00, 2);
        chk("illC0_data", {24'd0, out_data}, 32'h00);
        run_cmd(8'h24, 8'h00, 8'h00, 0);
        chk("acc_kept_data", {24'd0, out_data}, 32'h81);
        run_cmd(8'h02, 8'hF0, 8'h3C, 1);
        chk("and_data", {24'd0, out_data}, 32'h30);

        send_byte(8'h00);
        send_byte(8'h11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = 8'h00;
        chk_reset_vals();

        send_byte(8'h07);
        exp_data = 8'h00; exp_flags = 5'b10000; exp_vld = 1'b1;
        chk("ill07_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        exp_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_vals();

        run_cmd(8'h24, 8'h00, 8'h00, 0);
        chk("acc_cleared_flags", {27'd0, out_flags}, 32'b00001);
        run_cmd(8'h00, 8'h10, 8'h20, 0);
        chk("post_rst_add", {24'd0, out_data}, 32'h30);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Byte-serial command front end for the ALU. It sits directly upstream of `ALU_simple` and accepts an opcode byte followed by 0–2 operand bytes over a valid/ready stream. It drives the ALU, registers the result and flags, and presents them on a valid/ready output stream. It also keeps an 8-bit accumulator, so results can be chained without reloading operand A.

## Interface
Parameters:
- none. Widths are fixed at 8-bit data, 3-bit ALU opcode and 2-bit shift amount.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `in_data` in 8: command/operand byte
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: block accepts a byte this cycle
- `out_data` out 8: registered ALU result
- `out_flags` out 5: [4] err, [3] ovf, [2] carry, [1] neg, [0] zero
- `out_valid` out 1: result/flags valid
- `out_ready` in 1: consumer takes result this cycle
- `busy` out 1: state ≠ S_OP

## Operation
- **Opcode byte:**
  - [2:0] ALU op: 000 add, 001 sub, 010 and, 011 or, 100 shl, 101 shr.
  - [4:3] shift amount.
  - [5] use_acc.
  - [7:6] reserved, must be 0.
- **Byte accepted:** `in_valid && in_ready` at a rising edge.
- **FSM states:** S_OP, S_A, S_B, S_EXEC, S_OUT. Reset state is S_OP.
  - S_OP, accept → latch op.
    - Illegal (op 110/111 or [7:6] ≠ 0) → S_OUT with err.
    - Else use_acc → (shift op ? S_EXEC : S_B).
    - Else → S_A.
  - S_A, accept → latch A; shift op ? S_EXEC : S_B.
  - S_B, accept → latch B; → S_EXEC.
  - S_EXEC (exactly 1 cycle) → drive ALU from latched regs (A = acc when use_acc); capture `Result`/flags into output regs and acc → S_OUT.
  - S_OUT: `out_valid` = 1; on `out_ready` → S_OP.
- **Operand B for shift ops:** not collected; internal B register forced to 0x00.
- **`in_ready` rule:** equals 1 only in S_OP, S_A, S_B. No byte is accepted in S_EXEC/S_OUT, regardless of `in_valid`.
- **Carry masking:** shr with shift amount 0 → captured carry forced 0. The ALU's out-of-range bit index is never used. shl carry is taken as the ALU produces it.
- **Illegal command:**
  - `out_data` = 0x00, `out_flags` = 5'b10000.
  - acc unchanged, no operand bytes consumed.
  - Next byte is a fresh opcode.
- **Accumulator:** updated to result on every legal S_EXEC capture. Reset value 0x00.
- **Arithmetic:** all 8-bit, wrap modulo 256. Flags are exactly the ALU's Zero/Negative/Carry/Overflow for that op (sub carry = borrow), except the shr masking above.

## Timing
- **Reset values:** `in_ready` = 1, `out_valid` = 0, `out_data` = 0x00, `out_flags` = 0, `busy` = 0, acc = 0, all operand/op regs = 0, state S_OP.
- **Latency:** last byte accepted at edge k → S_EXEC during cycle k→k+1 → `out_valid` high after edge k+1.
- **Illegal opcode latency:** opcode accepted at edge k → `out_valid` high after edge k.
- **Throughput:** full add = 3 input cycles + 1 exec + ≥1 output cycle. Back-to-back commands are allowed. A new opcode may be accepted in the cycle after the output handshake.
- **Output hold:** `out_data`/`out_flags` stay stable while `out_valid && !out_ready`. They keep their last value after the handshake until the next capture.
- **Input stall:** gaps (`in_valid` = 0) in any collect state hold state and latched bytes indefinitely; there is no timeout.
- **Reset mid-command** (any state, including S_OUT with `out_valid` = 1): next cycle all outputs are at reset values; partial operands are discarded and acc is cleared.
- **Reset priority:** `rst` wins over a simultaneous input or output handshake.

## Structure
- **Package `alu_cmd_pkg`:**
  - ALU opcode constants (ADD…SHR).
  - opcode-byte field positions.
  - `out_flags` bit indices.
  - FSM state enum.
- **Sub-module:** one instance of the existing `ALU_simple` as the datapath. No other sub-modules; FSM, operand regs, acc and output regs are local.

## Test plan
- **Add:** bytes 0x00, 0x7F, 0x01 → `out_data` 0x80, flags 5'b01010 (ovf, neg); `out_valid` one cycle after the last accept.
- **Sub:** bytes 0x01, 0x05, 0x07 → 0xFE, flags 5'b00110 (borrow, neg); acc = 0xFE.
- **Accumulator shift:** next byte 0x2C (shl, shift 1, use_acc) → only one byte consumed; result 0xFC, carry = 1 (acc bit6), neg = 1.
- **Shift-by-zero masking:** 0x05, 0x81 (shr, shift 0) → 0x81, carry 0, neg 1, `in_ready` low after the A byte.
- **Illegal opcodes:** 0x06 → 0x00/5'b10000, acc unchanged; 0xC0 → same; a following 0x02, 0xF0, 0x3C → 0x30.
- **Backpressure and reset:**
  - Hold `out_ready` = 0 for 5 cycles → `out_valid`, `out_data`, `out_flags` stable and `in_ready` = 0.
  - Separately, `rst` after opcode + A accepted → all reset values next cycle; a subsequent full add command completes correctly.
